mips_ciclo_unico: RTL and testbench

//  Single-cycle 32-bit MIPS core. Each rising clock edge fetches, decodes and executes one instruction.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/mips_dmem.sv | 30 +++
 rtl/mips_regfile.sv | 30 +++
 rtl/mips_ciclo_unico.sv | 125 ++++++++++++
 tb/tb_mips_ciclo_unico.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct codes, ALU operation enum and control-signal bundle
// shared by the single-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_EXT_IMM_EN
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;
        logic    alu_src;
        logic    imm_zext;
        logic    mem_to_reg;
        logic    mem_write;
        logic    branch;
        logic    jump;
        alu_op_t alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_dmem.sv
// mips_dmem: word-addressed data RAM, combinational read, write on rising edge.
//   clk, reset : clock, async active-high reset clearing every word
//   addr       : word index (already reduced modulo DMEM_WORDS)
//   we, wd     : write enable and data
//   rd         : read data (old value during a same-cycle write)
module mips_dmem #(
    parameter int DMEM_WORDS = 64,
    parameter int DW         = $clog2(DMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] memory [0:DMEM_WORDS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) memory[i] <= '0;
        end else if (we) begin
            memory[addr] <= wd;
        end
    end

    assign rd = memory[addr];

endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two combinational read ports, one write port.
//   clk, reset      : clock, async active-high reset clearing every register
//   ra1, ra2 -> rd1, rd2 : read ports (old value during a same-cycle write)
//   wa, we, wd      : write port; writes to $0 are dropped so it always reads 0
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] registradores [0:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registradores[i] <= '0;
        end else if (we && wa != 5'd0) begin
            registradores[wa] <= wd;
        end
    end

    assign rd1 = registradores[ra1];
    assign rd2 = registradores[ra2];

endmodule

// File: rtl/mips_ciclo_unico.sv
// mips_ciclo_unico: single-cycle 32-bit MIPS core with internal ROM, register file and data RAM
module mips_ciclo_unico
  import mips_pkg::*;
#(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string INIT_FILE  = ""
) (
  input logic clk,
  input logic reset
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  function automatic logic [IMEM_WORDS*32-1:0] load_rom();
    logic [IMEM_WORDS*32-1:0] r;
    r = '0;
    if (INIT_FILE == "") begin
      r[0*32 +: 32] = 32'h20010005;
      r[1*32 +: 32] = 32'h20020007;
      r[2*32 +: 32] = 32'h00221820;
      r[3*32 +: 32] = 32'hAC030000;
      r[4*32 +: 32] = 32'h8C040000;
      r[5*32 +: 32] = 32'h1000FFFF;
    end
    return r;
  endfunction
  logic [IMEM_WORDS*32-1:0] imem = load_rom();
  logic [31:0]   pc, pc_plus4, pc_next, instr;
  logic [31:0]   rd1, rd2, imm_ext, srcb, alu_res, mem_rd, wd;
  logic [IW-1:0] iidx;
  logic [DW-1:0] midx;
  logic [4:0]    wa;
  ctrl_t         ctl;
  assign iidx  = IW'(pc >> 2);
  assign instr = ((pc >> 2) < IMEM_WORDS) ? imem[32*iidx +: 32] : '0;
  always_comb begin
    ctl = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        case (instr[5:0])
          FN_ADD:  ctl.alu_op = ALU_ADD;
          FN_SUB:  ctl.alu_op = ALU_SUB;
          FN_AND:  ctl.alu_op = ALU_AND;
          FN_OR:   ctl.alu_op = ALU_OR;
          FN_SLT:  ctl.alu_op = ALU_SLT;
          default: ctl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctl.reg_write  = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
      end
      OP_BEQ: ctl.branch = 1'b1;
      OP_J:   ctl.jump   = 1'b1;
`ifdef MIPS_EXT_IMM_EN
      OP_ANDI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.imm_zext  = 1'b1;
        ctl.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.imm_zext  = 1'b1;
        ctl.alu_op    = ALU_OR;
      end
      OP_SLTI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_op    = ALU_SLT;
      end
`endif
      default: ;
    endcase
  end
  assign imm_ext = ctl.imm_zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
  assign srcb    = ctl.alu_src ? imm_ext : rd2;
  assign alu_res = (ctl.alu_op == ALU_SUB) ? rd1 - srcb :
                   (ctl.alu_op == ALU_AND) ? rd1 & srcb :
                   (ctl.alu_op == ALU_OR)  ? rd1 | srcb :
                   (ctl.alu_op == ALU_SLT) ? {31'b0, $signed(rd1) < $signed(srcb)} :
                                             rd1 + srcb;
  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = ctl.jump                   ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                    (ctl.branch && rd1 == rd2) ? pc_plus4 + (imm_ext << 2) :
                                                 pc_plus4;
  assign midx = DW'((alu_res >> 2) % DMEM_WORDS);
  assign wd   = ctl.mem_to_reg ? mem_rd : alu_res;
  assign wa   = ctl.reg_dst ? instr[15:11] : instr[20:16];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end
  mips_regfile regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (wa),
    .we    (ctl.reg_write),
    .wd    (wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );
  mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
    .clk   (clk),
    .reset (reset),
    .addr  (midx),
    .we    (ctl.mem_write),
    .wd    (rd2),
    .rd    (mem_rd)
  );
endmodule

// File: tb/tb_mips_ciclo_unico.sv
// tb_mips_ciclo_unico: scoreboard bench for the single-cycle MIPS core.
// An ISA-level interpreter predicts the architectural state after every retired
// instruction; a monitor compares it with the core's PC, registers and RAM.
module tb_mips_ciclo_unico;

    localparam int IMEM = 64;
    localparam int DMEM = 64;
`ifdef MIPS_EXT_IMM_EN
    localparam logic [31:0] ORI_EXP = 32'h0000FFFF;
`else
    localparam logic [31:0] ORI_EXP = 32'h0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mips_ciclo_unico #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          ri;
        logic [31:0] rv;
        int          mi;
        logic [31:0] mv;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] prog [IMEM];
    logic [31:0] m_r  [32];
    logic [31:0] m_m  [DMEM];
    logic [31:0] m_pc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_r[i] = '0;
        for (int i = 0; i < DMEM; i++) m_m[i] = '0;
    endtask

    // Executes one instruction architecturally; reports which register and
    // RAM word were written (-1 if none).
    task automatic model_step(output int wr, output int wm);
        logic [31:0] ins, a, b, se, ze, nx, res;
        logic [5:0]  op, fn;
        int          rs, rt, rd, dst, idx;
        bit          w;
        ins = ((m_pc >> 2) < IMEM) ? prog[int'(m_pc >> 2)] : 32'h0;
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        a   = m_r[rs];
        b   = m_r[rt];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        nx  = m_pc + 4;
        res = '0;
        dst = 0;
        w   = 0;
        wr  = -1;
        wm  = -1;
        idx = int'(((a + se) >> 2) % DMEM);
        case (op)
            6'h00: begin
                w   = 1;
                dst = rd;
                case (fn)
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: w = 0;
                endcase
            end
            6'h08: begin w = 1; dst = rt; res = a + se; end
            6'h23: begin w = 1; dst = rt; res = m_m[idx]; end
            6'h2B: begin m_m[idx] = b; wm = idx; end
            6'h04: if (a == b) nx = nx + (se << 2);
            6'h02: nx = {nx[31:28], ins[25:0], 2'b00};
`ifdef MIPS_EXT_IMM_EN
            6'h0C: begin w = 1; dst = rt; res = a & ze; end
            6'h0D: begin w = 1; dst = rt; res = a | ze; end
            6'h0A: begin w = 1; dst = rt; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
`endif
            default: ;
        endcase
        if (w && dst != 0) begin
            m_r[dst] = res;
            wr = dst;
        end
        m_pc = nx;
    endtask

    // Monitor: architectural state is stable at the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", dut.pc, e.pc);
            chk($sformatf("reg[%0d]", e.ri), dut.regfile.registradores[e.ri], e.rv);
            chk($sformatf("mem[%0d]", e.mi), dut.dmem.memory[e.mi], e.mv);
        end
    end

    task automatic run_cycles(int n);
        int   wr, wm;
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            model_step(wr, wm);
            e.ri = (wr >= 0) ? wr : int'($urandom_range(0, 31));
            e.mi = (wm >= 0) ? wm : int'($urandom_range(0, DMEM - 1));
            e.pc = m_pc;
            e.rv = m_r[e.ri];
            e.mv = m_m[e.mi];
            sb.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_all(string tag);
        chk({tag, " pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s reg[%0d]", tag, i), dut.regfile.registradores[i], m_r[i]);
        for (int i = 0; i < DMEM; i++)
            chk($sformatf("%s mem[%0d]", tag, i), dut.dmem.memory[i], m_m[i]);
    endtask

    // Called just after a falling edge: reset, load the ROM, release before the next rising edge.
    task automatic restart();
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < IMEM; i++) dut.imem[i*32 +: 32] = prog[i];
        check_all("reset");
        #1 reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        int          rs  = int'($urandom_range(0, 7));
        int          rt  = int'($urandom_range(0, 7));
        int          rd  = int'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        logic [31:0] w;
        case ($urandom_range(0, 14))
            0:  w = enc_r(rs, rt, rd, 6'h20);
            1:  w = enc_r(rs, rt, rd, 6'h22);
            2:  w = enc_r(rs, rt, rd, 6'h24);
            3:  w = enc_r(rs, rt, rd, 6'h25);
            4:  w = enc_r(rs, rt, rd, 6'h2A);
            5:  w = enc_r(rs, rt, rd, 6'h27);
            6:  w = enc_i(6'h08, rs, rt, imm);
            7:  w = enc_i(6'h23, rs, rt, 16'($urandom_range(0, 255)));
            8:  w = enc_i(6'h2B, rs, rt, 16'($urandom_range(0, 255)));
            9:  w = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 6) - 2));
            10: w = {6'h02, 26'($urandom_range(0, 79))};
            11: w = enc_i(6'h0C, rs, rt, imm);
            12: w = enc_i(6'h0D, rs, rt, imm);
            13: w = enc_i(6'h0A, rs, rt, imm);
            default: w = enc_i(6'h3F, rs, rt, imm);
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < IMEM; i++) prog[i] = '0;
        prog[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog[1] = enc_i(6'h08, 0, 2, 16'd7);
        prog[2] = enc_r(1, 2, 3, 6'h20);
        prog[3] = enc_i(6'h2B, 0, 3, 16'd0);
        prog[4] = enc_i(6'h23, 0, 4, 16'd0);
        prog[5] = enc_i(6'h04, 0, 0, 16'hFFFF);

        #1 reset = 1'b1;
        model_reset();
        #1 check_all("power-on reset");
        #10 reset = 1'b0;
        run_cycles(3);
        #6 reset = 1'b1;
        model_reset();
        #1 check_all("mid-run reset");
        #4 reset = 1'b0;
        run_cycles(10);
        chk("builtin $1", dut.regfile.registradores[1], 32'd5);
        chk("builtin $2", dut.regfile.registradores[2], 32'd7);
        chk("builtin $3", dut.regfile.registradores[3], 32'd12);
        chk("builtin $4", dut.regfile.registradores[4], 32'd12);
        chk("builtin mem[0]", dut.dmem.memory[0], 32'd12);
        chk("builtin halt pc", dut.pc, 32'h14);
        check_all("builtin");

        for (int i = 0; i < IMEM; i++) prog[i] = '0;
        prog[0]  = enc_i(6'h08, 0, 1, 16'd2);
        prog[1]  = enc_i(6'h08, 0, 2, 16'hFFFF);
        prog[2]  = enc_r(1, 2, 5, 6'h22);
        prog[3]  = enc_r(2, 1, 6, 6'h2A);
        prog[4]  = enc_r(1, 2, 7, 6'h2A);
        prog[5]  = enc_i(6'h08, 0, 0, 16'd9);
        prog[6]  = enc_r(0, 0, 12, 6'h20);
        prog[7]  = enc_i(6'h08, 0, 8, 16'd3);
        prog[8]  = enc_i(6'h08, 0, 9, 16'd3);
        prog[9]  = enc_i(6'h04, 8, 9, 16'd1);
        prog[10] = enc_i(6'h08, 0, 10, 16'd1);
        prog[11] = enc_i(6'h0D, 0, 11, 16'hFFFF);
        prog[12] = enc_i(6'h04, 8, 2, 16'd1);
        prog[13] = enc_i(6'h08, 0, 13, 16'd1);
        prog[14] = enc_i(6'h04, 0, 0, 16'hFFFF);
        restart();
        run_cycles(25);
        chk("sub $5", dut.regfile.registradores[5], 32'd3);
        chk("slt $6", dut.regfile.registradores[6], 32'd1);
        chk("slt $7", dut.regfile.registradores[7], 32'd0);
        chk("write $0", dut.regfile.registradores[0], 32'd0);
        chk("add $12 from $0", dut.regfile.registradores[12], 32'd0);
        chk("beq taken skip $10", dut.regfile.registradores[10], 32'd0);
        chk("beq not taken $13", dut.regfile.registradores[13], 32'd1);
        chk("ori $11", dut.regfile.registradores[11], ORI_EXP);
        chk("directed halt pc", dut.pc, 32'h38);
        check_all("directed");

        repeat (5) begin
            for (int i = 0; i < IMEM; i++) prog[i] = (i < 56) ? rand_instr() : 32'h0;
            restart();
            run_cycles(200);
            check_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
